// File: rtl/video_arith_pkg.sv
// Shared types and constants for the video arithmetic arbiter.
// The arbitration policy is selected by the VIDEO_ARITH_RR_EN macro.
package video_arith_pkg;

   typedef enum logic {OP_MUL, OP_DIV} arith_op_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arith_state_t;

   localparam int ARITH_W_OP  = 12;
   localparam int ARITH_W_RES = 24;
   localparam logic [ARITH_W_RES-1:0] DIV0_RESULT = 24'hFFFFFF;

endpackage

// File: rtl/sys_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, run high for AW
// cycles after start; the quotient holds until the next start.
module sys_udiv #(
   parameter int AW = 24,
   parameter int BW = 12
) (
   input  logic          clk_i,
   input  logic          start_i,
   input  logic [AW-1:0] a_i,
   input  logic [BW-1:0] b_i,
   output logic          run_o,
   output logic [AW-1:0] q_o
);

   localparam int CW = $clog2(AW + 1);

   logic [BW-1:0] rem_q;
   logic [AW-1:0] quo_q;
   logic [BW-1:0] dvs_q;
   logic [CW-1:0] cnt_q;
   logic          run_q;
   logic [BW:0]   trial;
   logic [BW:0]   diff;
   logic          fits;

   assign trial = {rem_q, quo_q[AW-1]};
   assign fits  = (trial >= {1'b0, dvs_q});
   assign diff  = trial - {1'b0, dvs_q};

   // The remainder stays below the divisor, so it always fits in BW bits.
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         rem_q <= '0;
         quo_q <= a_i;
         dvs_q <= b_i;
         cnt_q <= CW'(AW);
         run_q <= 1'b1;
      end else if (run_q) begin
         rem_q <= fits ? diff[BW-1:0] : trial[BW-1:0];
         quo_q <= {quo_q[AW-2:0], fits};
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            run_q <= 1'b0;
         end
      end
   end

   assign run_o = run_q;
   assign q_o   = quo_q;

endmodule

// File: rtl/sys_umul.sv
// Serial shift-add unsigned multiplier: start latches the operands, run stays
// high for BW cycles, and the product holds until the next start.
module sys_umul #(
   parameter int AW = 12,
   parameter int BW = 12
) (
   input  logic             clk_i,
   input  logic             start_i,
   input  logic [AW-1:0]    a_i,
   input  logic [BW-1:0]    b_i,
   output logic             run_o,
   output logic [AW+BW-1:0] p_o
);

   localparam int PW = AW + BW;
   localparam int CW = $clog2(BW + 1);

   logic [PW-1:0] acc_q;
   logic [PW-1:0] mcand_q;
   logic [BW-1:0] mplier_q;
   logic [CW-1:0] cnt_q;
   logic          run_q;

   // No reset: a busy engine finishes its count on its own, and the arbiter
   // waits for run to fall before issuing new work.
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         acc_q    <= '0;
         mcand_q  <= PW'(a_i);
         mplier_q <= b_i;
         cnt_q    <= CW'(BW);
         run_q    <= 1'b1;
      end else if (run_q) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            run_q <= 1'b0;
         end
      end
   end

   assign run_o = run_q;
   assign p_o   = acc_q;

endmodule

// File: rtl/video_arith_pick.sv
// Grant picker for the arithmetic arbiter. With VIDEO_ARITH_RR_EN defined it
// is round-robin with a pointer register; otherwise lowest index wins.
module video_arith_pick
   import video_arith_pkg::*;
#(
   parameter int NREQ = 2
) (
`ifdef VIDEO_ARITH_RR_EN
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            advance_i,
`endif
   input  logic [NREQ-1:0] valid_i,
   output logic [NREQ-1:0] grant_o
);

`ifdef VIDEO_ARITH_RR_EN
   localparam int IW = $clog2(NREQ);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic          found;
   int            idx;

   // ptr_q holds the index the search starts from: one past the last winner.
   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && valid_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            if (advance_i) begin
               ptr_d = IW'((idx + 1) % NREQ);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && valid_i[k]) begin
            found      = 1'b1;
            grant_o[k] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/video_arith_arb.sv
// Shared multiply/divide arbiter for the video scaling path: one job in
// flight at a time. Arbitration policy selected by VIDEO_ARITH_RR_EN.
module video_arith_arb
   import video_arith_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DW   = 24
) (
   input  logic                       CLK_VIDEO,
   input  logic                       RESET,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_op,
   input  logic [NREQ*DW-1:0]         req_a,
   input  logic [NREQ*ARITH_W_OP-1:0] req_b,
   output logic [NREQ-1:0]            req_ready,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DW-1:0]              rsp_data,
   output logic                       busy
);

   arith_state_t           state_q;
   arith_op_t              opSel_q;
   logic [ARITH_W_RES-1:0] opA_q;
   logic [ARITH_W_OP-1:0]  opB_q;
   logic [NREQ-1:0]        grantOh_q;
   logic                   mulStart_q;
   logic                   divStart_q;
   logic [NREQ-1:0]        rspValid_q;
   logic [DW-1:0]          rspData_q;

   logic                   mulRun;
   logic                   divRun;
   logic [ARITH_W_RES-1:0] mulProd;
   logic [ARITH_W_RES-1:0] divQuo;
   logic [NREQ-1:0]        pickOh;
   logic                   canGrant;
   arith_op_t              selOp;
   logic [ARITH_W_RES-1:0] selA;
   logic [ARITH_W_OP-1:0]  selB;
   logic                   engineDone;
   logic [DW-1:0]          engineResult;

   // A still-running engine (e.g. left over from a reset) blocks new grants.
   assign canGrant  = (state_q == IDLE) && !RESET && !mulRun && !divRun && (|req_valid);
   assign req_ready = canGrant ? pickOh : '0;

`ifdef VIDEO_ARITH_RR_EN
   video_arith_pick #(.NREQ(NREQ)) u_pick (
      .clk_i     (CLK_VIDEO),
      .reset_i   (RESET),
      .advance_i (canGrant),
      .valid_i   (req_valid),
      .grant_o   (pickOh)
   );
`else
   video_arith_pick #(.NREQ(NREQ)) u_pick (
      .valid_i (req_valid),
      .grant_o (pickOh)
   );
`endif

   always_comb begin
      selOp = OP_MUL;
      selA  = '0;
      selB  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pickOh[i]) begin
            selOp = arith_op_t'(req_op[i]);
            selA  = req_a[i*DW +: ARITH_W_RES];
            selB  = req_b[i*ARITH_W_OP +: ARITH_W_OP];
         end
      end
   end

   assign engineDone   = (opSel_q == OP_MUL) ? (!mulStart_q && !mulRun)
                                             : (!divStart_q && !divRun);
   assign engineResult = (opSel_q == OP_MUL) ? DW'(mulProd) : DW'(divQuo);

   // Start pulses are set on the edge into ISSUE so they are high exactly
   // for the ISSUE cycle; divide-by-zero skips the engines entirely.
   always_ff @(posedge CLK_VIDEO) begin
      if (RESET) begin
         state_q    <= IDLE;
         opSel_q    <= OP_MUL;
         opA_q      <= '0;
         opB_q      <= '0;
         grantOh_q  <= '0;
         mulStart_q <= 1'b0;
         divStart_q <= 1'b0;
         rspValid_q <= '0;
         rspData_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (canGrant) begin
                  grantOh_q <= pickOh;
                  opSel_q   <= selOp;
                  opA_q     <= selA;
                  opB_q     <= selB;
                  if (selOp == OP_DIV && selB == '0) begin
                     rspValid_q <= pickOh;
                     rspData_q  <= DW'(DIV0_RESULT);
                     state_q    <= DONE;
                  end else begin
                     mulStart_q <= (selOp == OP_MUL);
                     divStart_q <= (selOp == OP_DIV);
                     state_q    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mulStart_q <= 1'b0;
               divStart_q <= 1'b0;
               state_q    <= WAIT;
            end
            WAIT: begin
               if (engineDone) begin
                  rspValid_q <= grantOh_q;
                  rspData_q  <= engineResult;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               rspValid_q <= '0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   sys_umul #(.AW(ARITH_W_OP), .BW(ARITH_W_OP)) u_mul (
      .clk_i   (CLK_VIDEO),
      .start_i (mulStart_q),
      .a_i     (opA_q[ARITH_W_OP-1:0]),
      .b_i     (opB_q),
      .run_o   (mulRun),
      .p_o     (mulProd)
   );

   sys_udiv #(.AW(ARITH_W_RES), .BW(ARITH_W_OP)) u_div (
      .clk_i   (CLK_VIDEO),
      .start_i (divStart_q),
      .a_i     (opA_q),
      .b_i     (opB_q),
      .run_o   (divRun),
      .q_o     (divQuo)
   );

   assign rsp_valid = rspValid_q;
   assign rsp_data  = rspData_q;
   assign busy      = (state_q != IDLE);

endmodule
